biquad_chain_ctrl: RTL and testbench

Sequencer and coefficient manager for a cascade of `NUM_STAGES` time-multiplexed biquad IIR instances, one per EQ band.
- Accepts one audio sample at a time and issues it to each enabled stage in order.
- Forwards each stage's result to the next stage and emits the final result with a valid strobe.
- Holds double-buffered coefficients so a configuration host can rewrite a band without disturbing a sample in flight.
- Sits between the audio input framer and the output serializer.

---
 rtl/biquad_chain_ctrl_pkg.sv | 20 ++
 rtl/biquad_chain_ctrl_if.sv | 24 ++
 rtl/biquad_chain_ctrl_coef_bank.sv | 75 +++++++
 rtl/biquad_chain_ctrl.sv | 144 ++++++++++++++
 tb/tb_biquad_chain_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biquad_chain_ctrl_pkg.sv
// Shared types and constants for the biquad cascade sequencer and its coefficient bank.
package biquad_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } ctrl_state_t;

  localparam int IDX_B0          = 0;
  localparam int IDX_B1          = 1;
  localparam int IDX_B2          = 2;
  localparam int IDX_A1          = 3;
  localparam int IDX_A2          = 4;
  localparam int COEFS_PER_STAGE = 5;

  localparam logic [3:0] BYPASS_ADDR = 4'd15;

endpackage

// File: rtl/biquad_chain_ctrl_if.sv
// Bus between the sequencer and the biquad filter instances.
interface biquad_chain_ctrl_if #(
  parameter int NUM_STAGES = 3
);
  // Strobe-only handshake, no ready: flt_valid[k] is a one-cycle request that
  // stage k consume flt_sample; stage k later answers with a one-cycle
  // flt_ovalid[k] while flt_out slice k carries its result.
  logic [NUM_STAGES-1:0]    flt_valid;
  logic [15:0]              flt_sample;
  logic [NUM_STAGES-1:0]    flt_ovalid;
  logic [16*NUM_STAGES-1:0] flt_out;
  logic [80*NUM_STAGES-1:0] flt_coef;

  modport master (
    output flt_valid, flt_sample, flt_coef,
    input  flt_ovalid, flt_out
  );

  modport slave (
    input  flt_valid, flt_sample, flt_coef,
    output flt_ovalid, flt_out
  );

endinterface

// File: rtl/biquad_chain_ctrl_coef_bank.sv
// Double-buffered coefficient and bypass storage: host writes go to the shadow
// bank, which is copied to the active bank only when the controller allows it.
module biquad_coef_bank
  import biquad_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_addr,
  input  logic [15:0]               cfg_data,
  input  logic                      cfg_commit,
  input  logic                      commit_ok,
  output logic [80*NUM_STAGES-1:0]  coef,
  output logic [NUM_STAGES-1:0]     bypass_next
);

  localparam int NC = NUM_STAGES * COEFS_PER_STAGE;

  logic [15:0]           shadow_q [NC];
  logic [15:0]           shadow_d [NC];
  logic [15:0]           active_q [NC];
  logic [NUM_STAGES-1:0] byp_shadow_q, byp_shadow_d, byp_active_q;
  logic                  pending_q;
  logic                  copy;

  // A commit strobe arriving in a safe cycle is honoured immediately, so a
  // sample accepted in the same IDLE cycle already sees the new bank.
  assign copy = commit_ok && (pending_q || cfg_commit);

  always_comb begin
    shadow_d     = shadow_q;
    byp_shadow_d = byp_shadow_q;
    if (cfg_we) begin
      if (cfg_addr == BYPASS_ADDR) begin
        byp_shadow_d = cfg_data[NUM_STAGES-1:0];
      end else if (int'(cfg_addr) < NC) begin
        shadow_d[cfg_addr] = cfg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NC; j++) begin
        shadow_q[j] <= '0;
        active_q[j] <= '0;
      end
      byp_shadow_q <= '1;
      byp_active_q <= '1;
      pending_q    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      byp_shadow_q <= byp_shadow_d;
      if (copy) begin
        active_q     <= shadow_d;
        byp_active_q <= byp_shadow_d;
        pending_q    <= 1'b0;
      end else if (cfg_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bypass_next = copy ? byp_shadow_d : byp_active_q;

  always_comb begin
    coef = '0;
    for (int j = 0; j < NC; j++) begin
      coef[16*j +: 16] = active_q[j];
    end
  end

endmodule

// File: rtl/biquad_chain_ctrl.sv
// Sequencer for a cascade of time-multiplexed biquad stages: issues each sample
// to every enabled stage in order, forwards results, and emits the chain output.
module biquad_chain_ctrl
  import biquad_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [15:0]         sample_in,
  output logic                out_valid,
  output logic [15:0]         sample_out,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  input  logic                cfg_commit,
  output logic                busy,
  output logic                overrun,
  output logic                fault,
  input  logic                clear_flags,
  biquad_chain_ctrl_if.master flt,
  output ctrl_state_t         dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  ctrl_state_t           state_q, state_d;
  logic [1:0]            stg_q, stg_d;
  logic [15:0]           cur_q, cur_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fault_set;
  logic [NUM_STAGES-1:0] bypass_next;
  logic [1:0]            first_stg, next_stg;
  logic                  has_first, has_next;

  biquad_coef_bank #(.NUM_STAGES(NUM_STAGES)) u_bank (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .commit_ok   ((state_q == IDLE) || (state_q == EMIT)),
    .coef        (flt.flt_coef),
    .bypass_next (bypass_next)
  );

  // Descending scan so the lowest qualifying stage index wins.
  always_comb begin
    first_stg = '0;
    next_stg  = '0;
    has_first = 1'b0;
    has_next  = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bypass_next[i]) begin
        first_stg = 2'(i);
        has_first = 1'b1;
        if (i > int'(stg_q)) begin
          next_stg = 2'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stg_d     = stg_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    fault_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          cur_d = sample_in;
          if (has_first) begin
            stg_d   = first_stg;
            state_d = ISSUE;
          end else begin
            state_d = EMIT;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (flt.flt_ovalid[stg_q]) begin
          cur_d = flt.flt_out[16*stg_q +: 16];
          if (has_next) begin
            stg_d   = next_stg;
            state_d = ISSUE;
          end else begin
            state_d = EMIT;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fault_set = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stg_q      <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      sample_out <= '0;
      overrun    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_q     <= stg_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      out_valid <= (state_d == EMIT);
      if (state_d == EMIT) sample_out <= cur_d;
      if (clear_flags)                              overrun <= 1'b0;
      else if (sample_valid && (state_q != IDLE))   overrun <= 1'b1;
      if (clear_flags)                              fault <= 1'b0;
      else if (fault_set)                           fault <= 1'b1;
    end
  end

  always_comb begin
    flt.flt_valid = '0;
    if (state_q == ISSUE) flt.flt_valid[stg_q] = 1'b1;
  end

  assign flt.flt_sample = cur_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_biquad_chain_ctrl.sv
// Self-checking bench: behavioural stage models (out = in + b0) and a chain-level
// reference computing expected output and latency from the enabled-stage set.
module tb_biquad_chain_ctrl;
  import biquad_ctrl_pkg::*;

  localparam int NS      = 3;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        out_valid;
  logic [15:0] sample_out;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        busy, overrun, fault;
  logic        clear_flags = 1'b0;
  ctrl_state_t dbg_state;

  biquad_chain_ctrl_if #(.NUM_STAGES(NS)) flt_bus ();

  biquad_chain_ctrl #(.NUM_STAGES(NS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .out_valid    (out_valid),
    .sample_out   (sample_out),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .busy         (busy),
    .overrun      (overrun),
    .fault        (fault),
    .clear_flags  (clear_flags),
    .flt          (flt_bus.master),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural stage models ----------------
  logic [NS-1:0]    ovalid_m = '0;
  logic [16*NS-1:0] fout_m = '0;
  int               mcnt [NS];
  logic [15:0]      mhold [NS];
  bit               stall [NS];

  assign flt_bus.flt_ovalid = ovalid_m;
  assign flt_bus.flt_out    = fout_m;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NS; k++) begin
      ovalid_m[k] = 1'b0;
      if (reset) begin
        mcnt[k] = 0;
      end else begin
        if (mcnt[k] > 0) begin
          mcnt[k]--;
          if (mcnt[k] == 0 && !stall[k]) begin
            ovalid_m[k] = 1'b1;
            fout_m[16*k +: 16] = mhold[k] + flt_bus.flt_coef[80*k +: 16];
          end
        end
        if (flt_bus.flt_valid[k]) begin
          mcnt[k]  = 7;
          mhold[k] = flt_bus.flt_sample;
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [15:0]   sh_b0 [NS];
  logic [15:0]   act_b0 [NS];
  logic [NS-1:0] sh_byp, act_byp;
  logic [15:0]   exp_q [$];
  int            pulse_q [$];
  logic [NS-1:0] pmask_q [$];

  function automatic logic [15:0] ref_out(input logic [15:0] s);
    logic [15:0] r = s;
    for (int k = 0; k < NS; k++) if (!act_byp[k]) r = r + act_b0[k];
    return r;
  endfunction

  function automatic int ref_lat();
    int e = 0;
    for (int k = 0; k < NS; k++) if (!act_byp[k]) e++;
    return 1 + 8 * e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin sh_b0[k] = '0; act_b0[k] = '0; end
    sh_byp = '1;
    act_byp = '1;
  endtask

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (a == BYPASS_ADDR) sh_byp = d[NS-1:0];
    else if (int'(a) < NS * COEFS_PER_STAGE && (int'(a) % COEFS_PER_STAGE) == IDX_B0)
      sh_b0[int'(a) / COEFS_PER_STAGE] = d;
  endtask

  task automatic commit_idle();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    act_b0 = sh_b0;
    act_byp = sh_byp;
  endtask

  // Leaves the bench at the negedge of cycle T+1.
  task automatic send_sample(input logic [15:0] s);
    @(negedge clk);
    sample_valid = 1'b1; sample_in = s;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [15:0] val, output bit got);
    got = 1'b0; val = '0; lat = 1;
    pulse_q.delete(); pmask_q.delete();
    repeat (80) begin
      if (flt_bus.flt_valid != '0) begin
        pulse_q.push_back(lat); pmask_q.push_back(flt_bus.flt_valid);
      end
      if (out_valid) begin got = 1'b1; val = sample_out; break; end
      @(negedge clk); lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({overrun, fault} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overrun, fault}); end
    checks++; if (sample_out !== 16'h0 || flt_bus.flt_sample !== 16'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", sample_out, flt_bus.flt_sample); end
    checks++; if (flt_bus.flt_valid !== '0 || flt_bus.flt_coef !== '0) begin failures++; $display("FAIL reset_flt got=%b/%h exp=0", flt_bus.flt_valid, flt_bus.flt_coef); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%s exp=IDLE", dbg_state.name()); end
  endtask

  task automatic test_passthrough();
    int lat; logic [15:0] val; bit got;
    send_sample(16'h1234);
    wait_result(lat, val, got);
    checks++; if (!got || lat != 1) begin failures++; $display("FAIL passthru_latency got=%0d(valid=%b) exp=1", lat, got); end
    checks++; if (val !== 16'h1234) begin failures++; $display("FAIL passthru_value got=%h exp=1234", val); end
    checks++; if (pulse_q.size() != 0) begin failures++; $display("FAIL passthru_flt_valid got=%0d pulses exp=0", pulse_q.size()); end
  endtask

  task automatic test_full_chain();
    int lat; logic [15:0] val; bit got;
    for (int k = 0; k < NS; k++) cfg_write(4'(k * COEFS_PER_STAGE + IDX_B0), 16'h0001);
    cfg_write(BYPASS_ADDR, 16'h0000);
    commit_idle();
    checks++; if (flt_bus.flt_coef[80*2 +: 16] !== 16'h0001 || flt_bus.flt_coef[80*1 +: 16] !== 16'h0001)
      begin failures++; $display("FAIL chain_coef_active got=%h exp=0001", flt_bus.flt_coef[80*2 +: 16]); end
    exp_q.push_back(ref_out(16'h0100));
    send_sample(16'h0100);
    wait_result(lat, val, got);
    checks++; if (pulse_q.size() != 3 || pulse_q[0] != 1 || pulse_q[1] != 9 || pulse_q[2] != 17)
      begin failures++; $display("FAIL chain_issue_times got=%p exp=1,9,17", pulse_q); end
    checks++; if (pmask_q.size() != 3 || pmask_q[0] !== 3'b001 || pmask_q[1] !== 3'b010 || pmask_q[2] !== 3'b100)
      begin failures++; $display("FAIL chain_issue_order got=%p exp=001,010,100", pmask_q); end
    checks++; if (!got || lat != 25) begin failures++; $display("FAIL chain_latency got=%0d exp=25", lat); end
    checks++; if (val !== exp_q[0] || val !== 16'h0103) begin failures++; $display("FAIL chain_value got=%h exp=%h", val, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_commit_deferral();
    int lat; bit got = 1'b0; bit early = 1'b0; logic [15:0] val = '0; logic [15:0] e;
    cfg_write(4'(1 * COEFS_PER_STAGE + IDX_B0), 16'h7FFF);
    e = ref_out(16'h0200);
    send_sample(16'h0200);
    for (lat = 1; lat < 60; lat++) begin
      if (out_valid) begin got = 1'b1; val = sample_out; break; end
      if (flt_bus.flt_coef[80*1 +: 16] !== 16'h0001) early = 1'b1;
      if (lat == 3) cfg_commit = 1'b1;
      if (lat == 4) cfg_commit = 1'b0;
      @(negedge clk);
    end
    checks++; if (early) begin failures++; $display("FAIL defer_no_change_in_flight got=changed exp=0001"); end
    checks++; if (!got || flt_bus.flt_coef[80*1 +: 16] !== 16'h0001)
      begin failures++; $display("FAIL defer_at_emit got=%h(valid=%b) exp=0001", flt_bus.flt_coef[80*1 +: 16], got); end
    checks++; if (val !== e) begin failures++; $display("FAIL defer_value got=%h exp=%h", val, e); end
    @(negedge clk);
    checks++; if (flt_bus.flt_coef[80*1 +: 16] !== 16'h7FFF)
      begin failures++; $display("FAIL defer_after_emit got=%h exp=7fff", flt_bus.flt_coef[80*1 +: 16]); end
    act_b0 = sh_b0; act_byp = sh_byp;
  endtask

  task automatic test_overrun();
    int lat; bit got = 1'b0; logic [15:0] val = '0; logic [15:0] a;
    a = 16'($urandom);
    exp_q.push_back(ref_out(a));
    send_sample(a);
    for (lat = 1; lat < 60; lat++) begin
      if (out_valid) begin got = 1'b1; val = sample_out; break; end
      if (lat == 5) begin sample_valid = 1'b1; sample_in = 16'($urandom); end
      if (lat == 6) sample_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (!got || lat != 25) begin failures++; $display("FAIL overrun_latency got=%0d exp=25", lat); end
    checks++; if (val !== exp_q[0]) begin failures++; $display("FAIL overrun_value got=%h exp=%h", val, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    checks++; if (overrun !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b/%b exp=0/0", overrun, fault); end
  endtask

  task automatic test_timeout();
    int lat; int flat = -1; bit saw_out = 1'b0; bit busy_at = 1'b1;
    int l2; logic [15:0] val; bit got;
    stall[1] = 1'b1;
    send_sample(16'h0AAA);
    for (lat = 1; lat < 60; lat++) begin
      if (out_valid) saw_out = 1'b1;
      if (fault) begin flat = lat; busy_at = busy; break; end
      @(negedge clk);
    end
    checks++; if (flat != 1 + 8 + 1 + TIMEOUT) begin failures++; $display("FAIL timeout_fault_time got=%0d exp=%0d", flat, 1 + 8 + 1 + TIMEOUT); end
    checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL timeout_idle got_busy=%b exp=0", busy_at); end
    checks++; if (saw_out) begin failures++; $display("FAIL timeout_no_output got=out_valid exp=none"); end
    stall[1] = 1'b0;
    exp_q.push_back(ref_out(16'h0555));
    send_sample(16'h0555);
    wait_result(l2, val, got);
    checks++; if (!got || val !== exp_q[0]) begin failures++; $display("FAIL timeout_next_sample got=%h(valid=%b) exp=%h", val, got, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", fault); end
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
  endtask

  task automatic test_random_chain();
    int lat; logic [15:0] val; bit got; logic [15:0] s; int el;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NS; k++) begin
        cfg_write(4'(k * COEFS_PER_STAGE + IDX_B0), 16'($urandom));
        cfg_write(4'(k * COEFS_PER_STAGE + $urandom_range(IDX_B1, IDX_A2)), 16'($urandom));
      end
      cfg_write(BYPASS_ADDR, 16'($urandom_range(0, 7)));
      commit_idle();
      s = 16'($urandom);
      exp_q.push_back(ref_out(s));
      el = ref_lat();
      send_sample(s);
      wait_result(lat, val, got);
      checks++; if (!got || lat != el) begin failures++; $display("FAIL rand_latency it=%0d mask=%b got=%0d exp=%0d", it, act_byp, lat, el); end
      checks++; if (val !== exp_q[0]) begin failures++; $display("FAIL rand_value it=%0d got=%h exp=%h", it, val, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_bypass_reset();
    int lat; logic [15:0] val; bit got; bit late_out = 1'b0; bit late_issue = 1'b0;
    cfg_write(4'(1 * COEFS_PER_STAGE + IDX_B0), 16'h0042);
    cfg_write(BYPASS_ADDR, 16'h0005);
    commit_idle();
    send_sample(16'h1000);
    wait_result(lat, val, got);
    checks++; if (!got || lat != 9) begin failures++; $display("FAIL bypass_latency got=%0d exp=9", lat); end
    checks++; if (pmask_q.size() != 1 || pmask_q[0] !== 3'b010) begin failures++; $display("FAIL bypass_issue got=%p exp=010", pmask_q); end
    checks++; if (val !== 16'h1042) begin failures++; $display("FAIL bypass_value got=%h exp=1042", val); end
    send_sample(16'h2000);
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== WAIT) begin failures++; $display("FAIL reset_pre_state got=%s exp=WAIT", dbg_state.name()); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b/%b exp=0/0", busy, out_valid); end
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (30) begin
      @(negedge clk);
      if (out_valid) late_out = 1'b1;
      if (flt_bus.flt_valid != '0) late_issue = 1'b1;
    end
    checks++; if (late_out || late_issue) begin failures++; $display("FAIL reset_abandon got=out%b/issue%b exp=0/0", late_out, late_issue); end
    checks++; if (flt_bus.flt_coef !== '0) begin failures++; $display("FAIL reset_coef got=%h exp=0", flt_bus.flt_coef); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_full_chain();
    test_commit_deferral();
    test_overrun();
    test_timeout();
    test_random_chain();
    test_bypass_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
